// File: rtl/tdm_pulse_synth.sv
// Time-multiplexed N-voice pulse-wave synthesizer: one shared accumulate datapath
// walks every voice once per sample tick and emits a saturated signed sample.
module tdm_pulse_synth #(
    parameter int VOICES   = 8,
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 32,
    parameter int FRAC     = 20,
    parameter int VOL_W    = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic [VOICES*PHASE_W-1:0]     phase_inc,
    input  logic [VOICES*8-1:0]           duty,
    input  logic [VOICES*VOL_W-1:0]       volume,
    input  logic [VOICES-1:0]             voice_enable,
    output logic signed [SAMPLE_W-1:0]    out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + (VOL_W - FRAC) + IDX_W + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t                     state, state_nxt;
    logic [IDX_W-1:0]           idx_p0;
    logic signed [ACC_W-1:0]    acc_p0;
    logic [PHASE_W-1:0]         phase_p0 [VOICES];

    logic [PHASE_W-1:0]         cur_phase;
    logic [PHASE_W-1:0]         cur_inc;
    logic [PHASE_W-1:0]         phase_nxt;
    logic [7:0]                 cur_duty;
    logic [VOL_W-1:0]           cur_vol;
    logic                       cur_en;
    logic                       level_pos;
    logic                       last_voice;
    logic signed [ACC_W-1:0]    amp_s;
    logic signed [ACC_W-1:0]    contrib;
    logic signed [ACC_W-1:0]    acc_sum;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[SAMPLE_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[SAMPLE_W-1:0];
        else
            return v[SAMPLE_W-1:0];
    endfunction

    // Slot select: the current voice's inputs and phase are read only in its own cycle
    assign cur_phase  = phase_p0[idx_p0];
    assign cur_inc    = phase_inc[idx_p0*PHASE_W +: PHASE_W];
    assign cur_duty   = duty[idx_p0*8 +: 8];
    assign cur_vol    = volume[idx_p0*VOL_W +: VOL_W];
    assign cur_en     = voice_enable[idx_p0];
    assign last_voice = (idx_p0 == IDX_W'(VOICES-1));

    // Level uses the pre-increment phase; a disabled voice parks its phase at zero
    assign level_pos  = (cur_phase[PHASE_W-1 -: 8] < cur_duty);
    assign amp_s      = signed'(ACC_W'({cur_vol, {(SAMPLE_W-2){1'b0}}} >> FRAC));
    assign phase_nxt  = cur_en ? (cur_phase + cur_inc) : '0;

    always_comb begin
        contrib = '0;
        if (cur_en)
            contrib = level_pos ? amp_s : -amp_s;
    end

    assign acc_sum = acc_p0 + contrib;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick)
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (last_voice)
                    state_nxt = SAT;
            end
            SAT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Accumulate stage: one voice per cycle; the final voice lands straight in out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_p0  <= '0;
            acc_p0  <= '0;
            out     <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < VOICES; i++)
                phase_p0[i] <= '0;
        end else begin
            if (sample_tick && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        acc_p0 <= '0;
                        idx_p0 <= '0;
                    end
                end
                ACCUM: begin
                    acc_p0           <= acc_sum;
                    idx_p0           <= idx_p0 + IDX_W'(1);
                    phase_p0[idx_p0] <= phase_nxt;
                    if (last_voice)
                        out <= saturate(acc_sum);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tdm_pulse_synth.md
Name: tdm_pulse_synth

Overview:
- Parametrised successor to the 8-voice square synthesizer.
- N pulse-wave voices, each with its own phase increment, duty cycle, volume and enable. Voices are evaluated time-multiplexed through one accumulate datapath, once per sample tick.
- Produces one saturated signed sample per tick, with a valid strobe, for the audio mixer.
- Adds over the previous block: variable duty, per-voice enable with hard phase restart, saturation, and an overrun flag.

Parameters:
- VOICES, 8, number of voices; power of two, 2..32.
- SAMPLE_W, 16, output sample width (signed).
- PHASE_W, 32, phase accumulator and increment width.
- FRAC, 20, fractional bits of volume; volume 1<<FRAC = 1.0.
- VOL_W, 24, volume input width per voice (unsigned, Q(VOL_W-FRAC).FRAC).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse requesting one output sample.
- phase_inc  in  VOICES*PHASE_W  per-voice phase increment; voice i at bits [i*PHASE_W +: PHASE_W].
- duty  in  VOICES*8  per-voice duty threshold.
- volume  in  VOICES*VOL_W  per-voice unsigned volume.
- voice_enable  in  VOICES  per-voice enable.
- out  out  SAMPLE_W  signed mixed sample, held between updates.
- out_valid  out  1  one-cycle pulse when out updates.
- busy  out  1  high while a frame is being computed.
- overrun  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset (async, active-high):
  - All phases = 0, accumulator = 0, state = IDLE.
  - out = 0, out_valid = 0, busy = 0, overrun = 0.
  - Reset mid-frame aborts the frame: no out_valid, out stays 0.
- FSM states: IDLE, ACCUM, SAT.
  - IDLE: on sample_tick, clear accumulator, voice index = 0, go to ACCUM. busy = 1 from the next cycle.
  - ACCUM: one voice per cycle, index 0..VOICES-1. After voice VOICES-1, go to SAT.
  - SAT: saturate the accumulator into out, pulse out_valid, go to IDLE. busy = 0 in IDLE.
  - Latency: out_valid is high exactly VOICES+1 cycles after the cycle where the tick is sampled. Ticks may be back-to-back once IDLE is reached.
- Per-voice slot i:
  - Inputs for voice i are sampled in its own ACCUM cycle. Host changes take effect at the next slot for that voice.
  - level = +1 if phase[i][PHASE_W-1 -: 8] < duty[i], else -1.
    - duty 0 gives constant -1.
    - duty 128 gives a square wave.
    - duty 255 is high for 255/256 of the period.
  - amp = (volume[i] << (SAMPLE_W-2)) >> FRAC, truncated, unsigned. Volume 1.0 gives 2^(SAMPLE_W-2).
  - Enabled voice: acc += level*amp, then phase[i] += phase_inc[i], mod 2^PHASE_W with natural wrap. The level is computed from the pre-increment phase.
  - Disabled voice: contributes 0 and phase[i] is forced to 0, so re-enabling restarts the phase.
- Arithmetic:
  - Accumulator is signed, width SAMPLE_W+(VOL_W-FRAC)+clog2(VOICES)+1. It never overflows internally.
  - SAT clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Overrun:
  - A sample_tick in ACCUM or SAT is ignored and sets overrun. The current frame is unaffected.
  - overrun is cleared only by reset.
- phase_inc = 0 holds the phase, giving a constant level (DC).

Test Plan (VOICES=8, SAMPLE_W=16, FRAC=20):
- Reset: assert reset asynchronously mid-ACCUM -> out=0, out_valid=0, busy=0, overrun=0 immediately; no out_valid follows.
- Single voice square: v0 enable, volume=1<<20, duty=128, inc=2^30; other voices disabled; 8 ticks -> out = 16384, 16384, -16384, -16384, repeated; each out_valid exactly 9 cycles after its tick.
- Two-voice mix: v0 and v1 volume=1<<19, duty=128, v0 inc=2^30, v1 inc=2^31 -> out = 16384, 0, 0, -16384, repeated.
- Saturation: all 8 voices volume=1<<21, inc=0, duty=255 -> out=32767; then duty=0 -> out=-32768.
- Overrun: ticks at cycle 0 and cycle 3 -> exactly one out_valid at cycle 9; overrun=1 and stays 1 through later clean ticks until reset.
- Enable restart: single-voice square above; disable v0 after 1 sample -> next out=0; re-enable -> out resumes 16384, 16384, -16384 from phase 0.
